// File: rtl/bsg_manycore_dmem_port_arbiter.sv
// bsg_manycore_dmem_port_arbiter
//   Shares the tile's single-port DMEM between the core's local load/store
//   path and remote accesses from network_rx. The core wins by default. A
//   starvation counter forces a remote grant once the remote has waited
//   starve_limit_p consecutive cycles. A small FSM remembers who owns the
//   read issued last cycle and steers mem_data_i back to that requester.
//
// Ports
//   clk_i, reset_n_i            clock, async active-low reset
//   core_*_i / core_stall_o     core request (valid/stall handshake)
//   core_rdata_o/_v_o           core read return (1 cycle after grant)
//   remote_*_i / remote_yumi_o  remote request (valid/yumi handshake)
//   remote_rdata_o/_v_o         remote read return (1 cycle after grant)
//   mem_*_o / mem_data_i        DMEM command and read data
//   starve_cnt_o                current starvation count
module bsg_manycore_dmem_port_arbiter #(
  parameter  int data_width_p   = 32,
  parameter  int dmem_size_p    = 1024,
  parameter  int starve_limit_p = 16,
  localparam int mask_width_lp  = data_width_p/8,
  localparam int addr_width_lp  = (dmem_size_p <= 1) ? 1 : $clog2(dmem_size_p),
  localparam int cnt_width_lp   = $clog2(starve_limit_p+1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     core_v_i,
  input  logic                     core_w_i,
  input  logic [addr_width_lp-1:0] core_addr_i,
  input  logic [data_width_p-1:0]  core_data_i,
  input  logic [mask_width_lp-1:0] core_mask_i,
  output logic                     core_stall_o,
  output logic [data_width_p-1:0]  core_rdata_o,
  output logic                     core_rdata_v_o,

  input  logic                     remote_v_i,
  input  logic                     remote_w_i,
  input  logic [addr_width_lp-1:0] remote_addr_i,
  input  logic [data_width_p-1:0]  remote_data_i,
  input  logic [mask_width_lp-1:0] remote_mask_i,
  output logic                     remote_yumi_o,
  output logic [data_width_p-1:0]  remote_rdata_o,
  output logic                     remote_rdata_v_o,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [data_width_p-1:0]  mem_data_o,
  output logic [mask_width_lp-1:0] mem_mask_o,
  input  logic [data_width_p-1:0]  mem_data_i,

  output logic [cnt_width_lp-1:0]  starve_cnt_o
);

  typedef struct packed {
    logic                     w;
    logic [addr_width_lp-1:0] addr;
    logic [data_width_p-1:0]  data;
    logic [mask_width_lp-1:0] mask;
  } dmem_req_s;

  typedef enum logic [1:0] {IDLE, CORE_RD, REMOTE_RD} rd_state_e;

  localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

  rd_state_e                state_r;
  logic [cnt_width_lp-1:0]  starve_cnt_r;
  logic                     force_remote;
  logic                     grant_core, grant_remote;
  dmem_req_s                core_req, remote_req, mem_req;

  assign core_req   = '{w: core_w_i,   addr: core_addr_i,   data: core_data_i,   mask: core_mask_i};
  assign remote_req = '{w: remote_w_i, addr: remote_addr_i, data: remote_data_i, mask: remote_mask_i};

  // Grants are gated by reset so nothing reaches DMEM while reset is held.
  assign force_remote = (starve_cnt_r == limit_lp);
  assign grant_remote = reset_n_i & remote_v_i & (force_remote | ~core_v_i);
  assign grant_core   = reset_n_i & core_v_i & ~grant_remote;

  assign remote_yumi_o = grant_remote;
  assign core_stall_o  = core_v_i & ~grant_core;
  assign mem_v_o       = grant_core | grant_remote;

  always_comb begin
    mem_req = '0;
    if (grant_core)        mem_req = core_req;
    else if (grant_remote) mem_req = remote_req;
  end

  assign mem_w_o    = mem_req.w;
  assign mem_addr_o = mem_req.addr;
  assign mem_data_o = mem_req.data;
  assign mem_mask_o = mem_req.mask;

  // Counts consecutive denied remote cycles; any grant or idle remote clears.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_r <= '0;
    end else if (grant_remote | ~remote_v_i) begin
      starve_cnt_r <= '0;
    end else if (starve_cnt_r != limit_lp) begin
      starve_cnt_r <= starve_cnt_r + cnt_width_lp'(1);
    end
  end

  assign starve_cnt_o = starve_cnt_r;

  // Owner of the read issued last cycle; every state can reach every state
  // so back-to-back reads from either side pipeline without bubbles.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else if (grant_core & ~core_w_i) begin
      state_r <= CORE_RD;
    end else if (grant_remote & ~remote_w_i) begin
      state_r <= REMOTE_RD;
    end else begin
      state_r <= IDLE;
    end
  end

  assign core_rdata_v_o   = (state_r == CORE_RD);
  assign remote_rdata_v_o = (state_r == REMOTE_RD);
  assign core_rdata_o     = core_rdata_v_o   ? mem_data_i : '0;
  assign remote_rdata_o   = remote_rdata_v_o ? mem_data_i : '0;

endmodule

// File: tb/tb_bsg_manycore_dmem_port_arbiter.sv
module tb_bsg_manycore_dmem_port_arbiter;

  localparam int DW    = 32;
  localparam int SIZE  = 64;
  localparam int LIMIT = 4;
  localparam int AW    = 6;
  localparam int MW    = DW/8;
  localparam int CW    = 3;

  logic          clk = 0;
  logic          rst_n;
  logic          cv, cw, rv, rw;
  logic [AW-1:0] ca, ra;
  logic [DW-1:0] cd, rd;
  logic [MW-1:0] cm, rm;
  logic          core_stall_o, core_rdata_v_o, remote_yumi_o, remote_rdata_v_o;
  logic [DW-1:0] core_rdata_o, remote_rdata_o;
  logic          mem_v_o, mem_w_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic [MW-1:0] mem_mask_o;
  logic [CW-1:0] starve_cnt_o;

  always #5 clk = ~clk;

  bsg_manycore_dmem_port_arbiter #(.data_width_p(DW), .dmem_size_p(SIZE), .starve_limit_p(LIMIT)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .core_v_i(cv), .core_w_i(cw), .core_addr_i(ca), .core_data_i(cd), .core_mask_i(cm),
    .core_stall_o(core_stall_o), .core_rdata_o(core_rdata_o), .core_rdata_v_o(core_rdata_v_o),
    .remote_v_i(rv), .remote_w_i(rw), .remote_addr_i(ra), .remote_data_i(rd), .remote_mask_i(rm),
    .remote_yumi_o(remote_yumi_o), .remote_rdata_o(remote_rdata_o), .remote_rdata_v_o(remote_rdata_v_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i), .starve_cnt_o(starve_cnt_o)
  );

  // DMEM model: synchronous single-port RAM with byte mask
  logic [DW-1:0] dmem [SIZE];
  initial begin
    for (int i = 0; i < SIZE; i++) dmem[i] = '0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      if (mem_v_o && mem_w_o) begin
        for (int b = 0; b < MW; b++)
          if (mem_mask_o[b]) dmem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      end else if (mem_v_o) begin
        mem_data_i <= dmem[mem_addr_o];
      end
    end
  end

  // Reference model state
  typedef struct { int due; logic [DW-1:0] data; } exp_t;
  exp_t          core_q[$], remote_q[$];
  logic [DW-1:0] ref_mem [SIZE];
  int            m_starve;
  int            mon_cyc;
  int            checks, failures;
  bit            last_gc, last_gr;

  initial begin
    mon_cyc = 0;
    forever begin
      @(posedge clk);
      mon_cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Checks combinational outputs for the inputs currently driven, then
  // advances the model as if the upcoming clock edge happens.
  task automatic step_check();
    bit fr, gr, gc, req_w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    fr = rst_n && (m_starve == LIMIT);
    gr = rst_n && rv && (fr || !cv);
    gc = rst_n && cv && !gr;
    check("yumi",   64'(remote_yumi_o), 64'(gr));
    check("stall",  64'(core_stall_o),  64'(cv && !gc));
    check("mem_v",  64'(mem_v_o),       64'(gc || gr));
    check("starve", 64'(starve_cnt_o),  64'(m_starve));
    req_w = 0; a = '0; d = '0; m = '0;
    if (gc) begin req_w = cw; a = ca; d = cd; m = cm; end
    else if (gr) begin req_w = rw; a = ra; d = rd; m = rm; end
    check("mem_cmd", 64'({mem_w_o, mem_addr_o, mem_data_o, mem_mask_o}), 64'({req_w, a, d, m}));
    if (gc || gr) begin
      if (req_w) begin
        for (int b = 0; b < MW; b++) if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else if (gc) core_q.push_back('{due: mon_cyc + 1, data: ref_mem[a]});
      else             remote_q.push_back('{due: mon_cyc + 1, data: ref_mem[a]});
    end
    if (!rst_n || gr || !rv) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    last_gc = gc;
    last_gr = gr;
  endtask

  task automatic tick();
    #1 step_check();
    @(negedge clk);
  endtask

  // Monitor: pops expectations whenever a read return shows up
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (core_rdata_v_o && remote_rdata_v_o) begin
        checks++; failures++;
        $display("FAIL both_valid actual=11 required=not-both t=%0t", $time);
      end
      if (core_rdata_v_o) begin
        checks++;
        if (core_q.size() == 0) begin
          failures++; $display("FAIL core_spurious actual=v required=none t=%0t", $time);
        end else begin
          e = core_q.pop_front();
          if (e.due != mon_cyc || e.data !== core_rdata_o) begin
            failures++;
            $display("FAIL core_rdata actual=%0h@%0d required=%0h@%0d", core_rdata_o, mon_cyc, e.data, e.due);
          end
        end
      end else if (core_q.size() > 0 && core_q[0].due <= mon_cyc) begin
        checks++; failures++;
        e = core_q.pop_front();
        $display("FAIL core_missing actual=none required=%0h@%0d", e.data, e.due);
      end
      if (remote_rdata_v_o) begin
        checks++;
        if (remote_q.size() == 0) begin
          failures++; $display("FAIL remote_spurious actual=v required=none t=%0t", $time);
        end else begin
          e = remote_q.pop_front();
          if (e.due != mon_cyc || e.data !== remote_rdata_o) begin
            failures++;
            $display("FAIL remote_rdata actual=%0h@%0d required=%0h@%0d", remote_rdata_o, mon_cyc, e.data, e.due);
          end
        end
      end else if (remote_q.size() > 0 && remote_q[0].due <= mon_cyc) begin
        checks++; failures++;
        e = remote_q.pop_front();
        $display("FAIL remote_missing actual=none required=%0h@%0d", e.data, e.due);
      end
    end
  end

  // Random traffic honoring the handshakes: a request is held until accepted.
  task automatic random_phase(input int cycles, input int pc, input int pr, input int amax);
    for (int i = 0; i < cycles; i++) begin
      if (!cv || last_gc) begin
        cv = ($urandom_range(99) < pc);
        cw = $urandom_range(1); ca = AW'($urandom_range(amax));
        cd = $urandom; cm = MW'($urandom_range(15));
      end
      if (!rv || last_gr) begin
        rv = ($urandom_range(99) < pr);
        rw = $urandom_range(1); ra = AW'($urandom_range(amax));
        rd = $urandom; rm = MW'($urandom_range(15));
      end
      tick();
    end
  endtask

  task automatic idle(input int n);
    cv = 0; rv = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks = 0; failures = 0; m_starve = 0; last_gc = 0; last_gr = 0;
    for (int i = 0; i < SIZE; i++) ref_mem[i] = '0;
    rst_n = 0;
    cv = 1; cw = 0; ca = 3; cd = '0; cm = '0;
    rv = 1; rw = 0; ra = 4; rd = '0; rm = '0;
    @(negedge clk);
    tick(); tick();                 // reset: no grants, stall follows core_v
    cv = 0; rv = 0;
    tick();
    rst_n = 1;
    idle(1);

    // core write then read of address 5
    cv = 1; cw = 1; ca = 5; cd = 32'hDEADBEEF; cm = 4'hF; tick();
    cw = 0; tick();
    idle(2);

    // remote writes 0x1234 to 7, then reads it back
    rv = 1; rw = 1; ra = 7; rd = 32'h1234; rm = 4'hF; tick();
    rw = 0; tick();
    idle(2);

    // remote masked write while core idle, then read back
    rv = 1; rw = 1; ra = 9; rd = 32'hAABBCCDD; rm = 4'b0101; tick();
    rw = 0; tick();
    idle(2);

    // starvation: both continuously reading; forced remote every 5th cycle
    cv = 1; cw = 0; ca = 5; rv = 1; rw = 0; ra = 7;
    for (int i = 0; i < 12; i++) tick();
    idle(2);

    // async reset while a remote read is in flight
    rv = 1; rw = 0; ra = 7; cv = 0;
    #1 step_check();
    @(posedge clk);
    #3 rst_n = 0;
    #1 check("rst_rvalid", 64'(remote_rdata_v_o), 64'(0));
    check("rst_cvalid", 64'(core_rdata_v_o), 64'(0));
    core_q.delete(); remote_q.delete();
    @(negedge clk);
    rv = 0; cv = 1; cw = 0; ca = 1;
    tick();                         // stall follows core_v in reset
    cv = 0; rst_n = 1;
    idle(3);

    // randomized mixes
    random_phase(300, 60, 60, 15);
    random_phase(200, 100, 90, 7);
    random_phase(200, 30, 30, SIZE-1);
    idle(4);
    check("drain_core",   64'(core_q.size()),   64'(0));
    check("drain_remote", 64'(remote_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
